// File: rtl/m216a_pe_stream_if.sv
// Sample-stream bus of the M216A processing element: instruction, qualified
// operands and the registered result with its one-cycle valid strobe.
interface m216a_pe_stream_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       instr;
    logic              s_valid;
    logic              clr;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] z;
    logic [DATA_W-1:0] result;
    logic              r_valid;

    modport master (output instr, s_valid, clr, x, y, z, input result, r_valid);
    modport slave  (input instr, s_valid, clr, x, y, z, output result, r_valid);
endinterface

// File: rtl/m216a_pe_stream.sv
// M216A processing element: eight instruction-selected functions on a
// valid-qualified sample stream, with fixed per-function latency.
module m216a_pe_stream #(
    parameter int DATA_W = 16,
    parameter int SAT_EN = 0,
    parameter int COEF   = 7
) (
    input logic              Clk_In,
    input logic              Rst_In,
    m216a_pe_stream_if.slave pe
);
    localparam int WIDE_W = 2 * DATA_W + 1;
    localparam int NSTG   = 6;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [WIDE_W-1:0] wide_t;

    localparam wide_t COEF_W = wide_t'(COEF);

    logic [3:0]      op;
    word_t           hist1;
    word_t           hist2;
    word_t           acc;
    word_t           pipe_d [NSTG];
    logic [NSTG-1:0] pipe_v;
    word_t           d_out_q;
    logic            v_out_q;

    logic            flush;
    logic            legal;
    logic            take;
    logic            use_acc;
    logic [2:0]      tap;
    word_t           hist1_eff;
    word_t           hist2_eff;
    word_t           acc_eff;
    word_t           result;
    wide_t           raw;
    logic            unused_instr;

    function automatic word_t reduce(input wide_t v);
        if (SAT_EN != 0 && |v[WIDE_W-1:DATA_W]) return '1;
        return v[DATA_W-1:0];
    endfunction

    assign unused_instr = ^pe.instr[15:4];
    assign flush        = pe.instr[3:0] != op;
    assign legal        = op >= 4'd1 && op <= 4'd8;
    assign take         = pe.s_valid && !flush && legal;
    assign use_acc      = op == 4'd6 || op == 4'd8;

    // A clear on the accepting edge is applied before the sample uses history.
    assign hist1_eff = pe.clr ? '0 : hist1;
    assign hist2_eff = pe.clr ? '0 : hist2;
    assign acc_eff   = pe.clr ? '0 : acc;

    always_comb begin
        raw = '0;
        case (op)
            4'd1, 4'd2: raw = wide_t'(pe.x);
            4'd3:       raw = wide_t'(pe.y) + wide_t'(pe.z);
            4'd4:       raw = wide_t'(pe.x) * wide_t'(pe.y);
            4'd5:       raw = wide_t'(pe.x) + wide_t'(pe.y) * wide_t'(pe.z);
            4'd6:       raw = wide_t'(acc_eff) + wide_t'(pe.z) * COEF_W;
            4'd7:       raw = wide_t'(hist2_eff) * wide_t'(hist1_eff) + wide_t'(pe.x);
            4'd8:       raw = wide_t'(acc_eff) + wide_t'(hist1_eff) * wide_t'(pe.x);
            default:    raw = '0;
        endcase
    end

    assign result = reduce(raw);

    // Result is computed on the accepting edge; the tap sets the total latency.
    always_comb begin
        tap = 3'd1;
        case (op)
            4'd2, 4'd7: tap = 3'd3;
            4'd8:       tap = 3'd5;
            default:    tap = 3'd1;
        endcase
    end

    always_ff @(posedge Clk_In or negedge Rst_In) begin
        if (!Rst_In) begin
            op      <= '0;
            hist1   <= '0;
            hist2   <= '0;
            acc     <= '0;
            pipe_v  <= '0;
            d_out_q <= '0;
            v_out_q <= 1'b0;
            for (int i = 0; i < NSTG; i++) pipe_d[i] <= '0;
        end else if (flush) begin
            op      <= pe.instr[3:0];
            pipe_v  <= '0;
            hist1   <= '0;
            hist2   <= '0;
            acc     <= '0;
            v_out_q <= 1'b0;
        end else begin
            pipe_v    <= {pipe_v[NSTG-2:0], take};
            pipe_d[0] <= result;
            for (int i = 1; i < NSTG; i++) pipe_d[i] <= pipe_d[i-1];
            v_out_q <= pipe_v[tap];
            if (pipe_v[tap]) d_out_q <= pipe_d[tap];
            if (pe.clr) begin
                hist1 <= '0;
                hist2 <= '0;
                acc   <= '0;
            end
            if (take) begin
                hist1 <= pe.x;
                hist2 <= hist1_eff;
                if (use_acc) acc <= result;
            end
        end
    end

    assign pe.result  = d_out_q;
    assign pe.r_valid = v_out_q;
endmodule

// File: tb/tb_m216a_pe_stream.sv
// Bench for m216a_pe_stream: three instances (16-bit wrap, 8-bit saturate,
// 8-bit wrap) share one stimulus stream; directed and randomized scenarios.
module tb_m216a_pe_stream;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        vin   = 1'b0;
    logic        clr   = 1'b0;
    logic [15:0] dx    = '0;
    logic [15:0] dy    = '0;
    logic [15:0] dz    = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    always #5 clk = ~clk;

    m216a_pe_stream_if #(.DATA_W(16)) bus0 ();
    m216a_pe_stream_if #(.DATA_W(8))  bus1 ();
    m216a_pe_stream_if #(.DATA_W(8))  bus2 ();

    assign bus0.instr = instr;  assign bus1.instr = instr;  assign bus2.instr = instr;
    assign bus0.s_valid = vin;  assign bus1.s_valid = vin;  assign bus2.s_valid = vin;
    assign bus0.clr = clr;      assign bus1.clr = clr;      assign bus2.clr = clr;
    assign bus0.x = dx;         assign bus1.x = dx[7:0];    assign bus2.x = dx[7:0];
    assign bus0.y = dy;         assign bus1.y = dy[7:0];    assign bus2.y = dy[7:0];
    assign bus0.z = dz;         assign bus1.z = dz[7:0];    assign bus2.z = dz[7:0];

    m216a_pe_stream #(.DATA_W(16), .SAT_EN(0), .COEF(7)) u0 (.Clk_In(clk), .Rst_In(rst_n), .pe(bus0));
    m216a_pe_stream #(.DATA_W(8),  .SAT_EN(1), .COEF(7)) u1 (.Clk_In(clk), .Rst_In(rst_n), .pe(bus1));
    m216a_pe_stream #(.DATA_W(8),  .SAT_EN(0), .COEF(7)) u2 (.Clk_In(clk), .Rst_In(rst_n), .pe(bus2));

    logic [2:0]  ov;
    logic [15:0] od [3];
    assign ov    = {bus2.r_valid, bus1.r_valid, bus0.r_valid};
    assign od[0] = bus0.result;
    assign od[1] = {8'h00, bus1.result};
    assign od[2] = {8'h00, bus2.result};

    // Reference model: per-channel sample history, accumulator and a list of
    // results scheduled for the cycle they are due.
    typedef struct { int ch; int due; longint val; } pend_t;
    pend_t       pq[$];
    logic [3:0]  m_op = '0;
    longint      m_h1 [3];
    longint      m_h2 [3];
    longint      m_acc [3];
    logic        exp_v [3];
    logic [15:0] exp_d [3];

    function automatic int width_of(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic longint fit(input int k, input longint v);
        longint top;
        top = longint'(1) << width_of(k);
        if (k == 1 && v >= top) return top - 1;
        return v % top;
    endfunction

    task automatic model_reset();
        pq.delete();
        m_op = '0;
        for (int k = 0; k < 3; k++) begin
            m_h1[k] = 0; m_h2[k] = 0; m_acc[k] = 0;
            exp_v[k] = 1'b0; exp_d[k] = '0;
        end
    endtask

    task automatic model_edge();
        longint xv, yv, zv, raw, r, mask;
        int lat;
        for (int k = 0; k < 3; k++) exp_v[k] = 1'b0;
        if (instr[3:0] != m_op) begin
            m_op = instr[3:0];
            pq.delete();
            for (int k = 0; k < 3; k++) begin m_h1[k] = 0; m_h2[k] = 0; m_acc[k] = 0; end
            return;
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < pq.size(); i++) begin
                if (pq[i].ch == k && pq[i].due == cyc) begin
                    exp_v[k] = 1'b1;
                    exp_d[k] = 16'(pq[i].val);
                    pq.delete(i);
                    break;
                end
            end
            mask = (longint'(1) << width_of(k)) - 1;
            xv = longint'(dx) & mask;
            yv = longint'(dy) & mask;
            zv = longint'(dz) & mask;
            if (clr) begin m_h1[k] = 0; m_h2[k] = 0; m_acc[k] = 0; end
            if (vin && m_op >= 4'd1 && m_op <= 4'd8) begin
                lat = 2;
                case (m_op)
                    4'd1: raw = xv;
                    4'd2: begin raw = xv; lat = 4; end
                    4'd3: raw = yv + zv;
                    4'd4: raw = xv * yv;
                    4'd5: raw = xv + yv * zv;
                    4'd6: raw = m_acc[k] + zv * 7;
                    4'd7: begin raw = m_h2[k] * m_h1[k] + xv; lat = 4; end
                    default: begin raw = m_acc[k] + m_h1[k] * xv; lat = 6; end
                endcase
                r = fit(k, raw);
                if (m_op == 4'd6 || m_op == 4'd8) m_acc[k] = r;
                m_h2[k] = m_h1[k];
                m_h1[k] = xv;
                pq.push_back('{k, cyc + lat, r});
            end
        end
    endtask

    logic [15:0] outs0[$];
    logic [15:0] outs1[$];
    logic [15:0] outs2[$];
    int          acc_c[$];
    int          out_c[$];

    task automatic clear_log();
        outs0.delete(); outs1.delete(); outs2.delete(); acc_c.delete(); out_c.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) model_reset();
        else model_edge();
    endtask

    task automatic cyc_drive(input logic v, input logic c, input logic [15:0] x,
                             input logic [15:0] y, input logic [15:0] z);
        vin = v; clr = c; dx = x; dy = y; dz = z;
        tick();
        if (v) acc_c.push_back(cyc);
        if (ov[0]) begin outs0.push_back(od[0]); out_c.push_back(cyc); end
        if (ov[1]) outs1.push_back(od[1]);
        if (ov[2]) outs2.push_back(od[2]);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic set_op(input logic [3:0] op);
        instr = {12'h000, op};
        cyc_drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || od[k] !== 16'd0) begin
                errors++;
                $display("FAIL reset_state ch%0d: got v=%b d=%0d want v=0 d=0", k, ov[k], od[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_f1();
        set_op(4'd1);
        clear_log();
        for (int i = 1; i <= 11; i++) cyc_drive(1'b1, 1'b0, 16'(i), 16'(3 * i), 16'd0);
        idle(6);
        checks++;
        if (outs0.size() != 11) begin
            errors++;
            $display("FAIL f1_count: got %0d want 11", outs0.size());
        end
        for (int i = 0; i < outs0.size() && i < 11; i++) begin
            checks++;
            if (outs0[i] !== 16'(i + 1)) begin
                errors++;
                $display("FAIL f1_value[%0d]: got %0d want %0d", i, outs0[i], i + 1);
            end
            checks++;
            if (out_c[i] - acc_c[i] != 2) begin
                errors++;
                $display("FAIL f1_latency[%0d]: got %0d want 2", i, out_c[i] - acc_c[i]);
            end
        end
    endtask

    task automatic test_f7_f8();
        int e7[9] = '{1, 2, 5, 10, 17, 26, 37, 50, 65};
        int e8[6] = '{0, 2, 8, 20, 40, 70};
        set_op(4'd7);
        clear_log();
        for (int i = 1; i <= 9; i++) cyc_drive(1'b1, 1'b0, 16'(i), 16'd0, 16'd0);
        idle(6);
        checks++;
        if (outs0.size() != 9) begin
            errors++;
            $display("FAIL f7_count: got %0d want 9", outs0.size());
        end
        for (int i = 0; i < outs0.size() && i < 9; i++) begin
            checks++;
            if (outs0[i] !== 16'(e7[i]) || out_c[i] - acc_c[i] != 4) begin
                errors++;
                $display("FAIL f7_value[%0d]: got %0d lat %0d want %0d lat 4",
                         i, outs0[i], out_c[i] - acc_c[i], e7[i]);
            end
        end
        set_op(4'd8);
        clear_log();
        for (int i = 1; i <= 6; i++) cyc_drive(1'b1, 1'b0, 16'(i), 16'd0, 16'd0);
        idle(8);
        checks++;
        if (outs0.size() != 6) begin
            errors++;
            $display("FAIL f8_count: got %0d want 6", outs0.size());
        end
        for (int i = 0; i < outs0.size() && i < 6; i++) begin
            checks++;
            if (outs0[i] !== 16'(e8[i]) || out_c[i] - acc_c[i] != 6) begin
                errors++;
                $display("FAIL f8_value[%0d]: got %0d lat %0d want %0d lat 6",
                         i, outs0[i], out_c[i] - acc_c[i], e8[i]);
            end
        end
    endtask

    task automatic test_f6_gaps();
        int s;
        int e1;
        set_op(4'd6);
        clear_log();
        for (int i = 0; i < 22; i++)
            cyc_drive((i % 2) == 0, 1'b0, 16'd0, 16'd0, 16'(8 + i / 2));
        idle(4);
        checks++;
        if (outs0.size() != 11 || outs1.size() != 11 || outs2.size() != 11) begin
            errors++;
            $display("FAIL f6_count: got %0d/%0d/%0d want 11", outs0.size(), outs1.size(), outs2.size());
        end
        s = 0;
        for (int j = 0; j < 11 && j < outs0.size() && j < outs1.size() && j < outs2.size(); j++) begin
            s = s + 7 * (8 + j);
            e1 = (s > 255) ? 255 : s;
            checks++;
            if (outs0[j] !== 16'(s) || out_c[j] - acc_c[j] != 2) begin
                errors++;
                $display("FAIL f6_w16[%0d]: got %0d lat %0d want %0d lat 2",
                         j, outs0[j], out_c[j] - acc_c[j], s);
            end
            checks++;
            if (outs1[j] !== 16'(e1) || outs2[j] !== 16'(s % 256)) begin
                errors++;
                $display("FAIL f6_w8[%0d]: got sat %0d wrap %0d want %0d %0d",
                         j, outs1[j], outs2[j], e1, s % 256);
            end
        end
    endtask

    task automatic test_sat8();
        set_op(4'd4);
        clear_log();
        cyc_drive(1'b1, 1'b0, 16'd20, 16'd20, 16'd0);
        idle(3);
        checks++;
        if (outs0.size() != 1 || outs1.size() != 1 || outs2.size() != 1) begin
            errors++;
            $display("FAIL f4_count: got %0d/%0d/%0d want 1", outs0.size(), outs1.size(), outs2.size());
        end else begin
            checks++;
            if (outs0[0] !== 16'd400 || outs1[0] !== 16'd255 || outs2[0] !== 16'd144) begin
                errors++;
                $display("FAIL f4_values: got %0d/%0d/%0d want 400/255/144", outs0[0], outs1[0], outs2[0]);
            end
        end
        set_op(4'd6);
        clear_log();
        repeat (4) cyc_drive(1'b1, 1'b0, 16'd0, 16'd0, 16'd40);
        idle(3);
        checks++;
        if (outs1.size() != 4 || outs2.size() != 4) begin
            errors++;
            $display("FAIL f6_sat_count: got %0d/%0d want 4", outs1.size(), outs2.size());
        end
        for (int j = 0; j < 4 && j < outs1.size() && j < outs2.size(); j++) begin
            checks++;
            if (outs1[j] !== 16'd255 || outs2[j] !== 16'((280 * (j + 1)) % 256)) begin
                errors++;
                $display("FAIL f6_sat[%0d]: got sat %0d wrap %0d want 255 %0d",
                         j, outs1[j], outs2[j], (280 * (j + 1)) % 256);
            end
        end
    endtask

    task automatic test_f5_reset();
        set_op(4'd5);
        clear_log();
        cyc_drive(1'b1, 1'b0, 16'd1, 16'd4, 16'd8);
        idle(2);
        checks++;
        if (outs0.size() != 1 || (outs0.size() == 1 && (outs0[0] !== 16'd33 || out_c[0] - acc_c[0] != 2))) begin
            errors++;
            $display("FAIL f5_value: got count %0d want one result 33 at latency 2", outs0.size());
        end
        clear_log();
        cyc_drive(1'b1, 1'b0, 16'd2, 16'd3, 16'd4);
        cyc_drive(1'b1, 1'b0, 16'd5, 16'd5, 16'd5);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || od[k] !== 16'd0) begin
                errors++;
                $display("FAIL midreset_clear ch%0d: got v=%b d=%0d want v=0 d=0", k, ov[k], od[k]);
            end
        end
        cyc_drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        rst_n = 1'b1;
        idle(8);
        checks++;
        if (outs0.size() + outs1.size() + outs2.size() != 0) begin
            errors++;
            $display("FAIL midreset_discard: got %0d results want 0", outs0.size() + outs1.size() + outs2.size());
        end
    endtask

    task automatic test_clr_f8();
        int e[5] = '{0, 2, 8, 0, 20};
        logic [3:0] bad[3] = '{4'd9, 4'd0, 4'd15};
        set_op(4'd8);
        clear_log();
        for (int i = 1; i <= 5; i++) cyc_drive(1'b1, i == 4, 16'(i), 16'd0, 16'd0);
        idle(8);
        checks++;
        if (outs0.size() != 5) begin
            errors++;
            $display("FAIL clr_count: got %0d want 5", outs0.size());
        end
        for (int i = 0; i < outs0.size() && i < 5; i++) begin
            checks++;
            if (outs0[i] !== 16'(e[i])) begin
                errors++;
                $display("FAIL clr_value[%0d]: got %0d want %0d", i, outs0[i], e[i]);
            end
        end
        for (int b = 0; b < 3; b++) begin
            set_op(bad[b]);
            clear_log();
            repeat (10) cyc_drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
            idle(8);
            checks++;
            if (outs0.size() + outs1.size() + outs2.size() != 0) begin
                errors++;
                $display("FAIL illegal_op%0d: got %0d results want 0", bad[b],
                         outs0.size() + outs1.size() + outs2.size());
            end
        end
    endtask

    task automatic test_flush();
        set_op(4'd1);
        clear_log();
        cyc_drive(1'b1, 1'b0, 16'd77, 16'd0, 16'd0);
        idle(3);
        set_op(4'd2);
        cyc_drive(1'b1, 1'b0, 16'd99, 16'd0, 16'd0);
        cyc_drive(1'b1, 1'b0, 16'd100, 16'd0, 16'd0);
        set_op(4'd1);
        idle(6);
        checks++;
        if (outs0.size() != 1 || od[0] !== 16'd77) begin
            errors++;
            $display("FAIL flush_discard: got %0d results, d=%0d want 1 result, d=77", outs0.size(), od[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 3) == 0) instr = 16'($urandom);
                else instr = {12'($urandom), 4'($urandom_range(1, 8))};
            end else if ($urandom_range(0, 19) == 0) begin
                instr[15:4] = 12'($urandom);
            end
            vin = $urandom_range(0, 3) != 0;
            clr = $urandom_range(0, 24) == 0;
            dx  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            dy  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            dz  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ov[k] !== exp_v[k] || od[k] !== exp_d[k]) begin
                    errors++;
                    $display("FAIL random ch%0d cyc%0d op%0d: got v=%b d=%0d want v=%b d=%0d",
                             k, cyc, m_op, ov[k], od[k], exp_v[k], exp_d[k]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        model_reset();
        test_reset();
        test_f1();
        test_f7_f8();
        test_f6_gaps();
        test_sat8();
        test_f5_reset();
        test_clr_f8();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
